pipe_hold: RTL and testbench

PIPE_HOLD -- requirements
Module: pipe_hold

---
 rtl/pipe_hold.sv | 253 +++++++++++++++++++++++++
 tb/tb_pipe_hold.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hold.sv
// -----------------------------------------------------------------------------
// pipe_hold
// Front-end pipeline hold/flush controller for a classic five-stage pipeline.
// Owns the fetch PC and the IF/ID and ID/EX pipeline registers, and decides
// once per cycle which single action applies to them:
//   reset > FREEZE (mem_wait) > STALL (do_stall) > FLUSH (branch_taken) > RUN
// It also reports the last action taken and saturating stall/flush counters.
//
// Ports
//   clk            : sole clock, rising edge
//   reset          : synchronous active-high reset
//   do_stall       : load-use stall request (hold PC and IF/ID, bubble ID/EX)
//   mem_wait       : data memory not ready (hold everything)
//   branch_taken   : branch resolved taken in ID
//   branch_target  : branch destination, used as given
//   if_instr       : instruction fetched at pc
//   id_memRead/id_memWrite/id_regWrite, id_rs/id_rt/id_rd : decoded ID fields
//   pc             : fetch address
//   IF_ID_*        : IF/ID pipeline register contents (rs/rt are slices)
//   ID_EX_*        : ID/EX pipeline register contents
//   state          : action taken at the last edge (0 RUN,1 STALL,2 FLUSH,3 FREEZE)
//   stall_count    : number of STALL cycles, saturating
//   flush_count    : number of FLUSH cycles, saturating
// -----------------------------------------------------------------------------
module pipe_hold (
    input  logic        clk,
    input  logic        reset,
    input  logic        do_stall,
    input  logic        mem_wait,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] if_instr,
    input  logic        id_memRead,
    input  logic        id_memWrite,
    input  logic        id_regWrite,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    output logic [31:0] pc,
    output logic [31:0] IF_ID_instr,
    output logic [31:0] IF_ID_pcplus4,
    output logic        IF_ID_valid,
    output logic [4:0]  IF_ID_rs,
    output logic [4:0]  IF_ID_rt,
    output logic        ID_EX_memRead,
    output logic        ID_EX_memWrite,
    output logic        ID_EX_regWrite,
    output logic        ID_EX_valid,
    output logic [4:0]  ID_EX_rs,
    output logic [4:0]  ID_EX_rt,
    output logic [4:0]  ID_EX_rd,
    output logic [1:0]  state,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    // Encoding doubles as the externally visible state code.
    typedef enum logic [1:0] {
        ACT_RUN    = 2'd0,
        ACT_STALL  = 2'd1,
        ACT_FLUSH  = 2'd2,
        ACT_FREEZE = 2'd3
    } action_t;

    // Saturating increment for the event counters.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    action_t     state_r;
    logic [31:0] pc_r;
    logic [31:0] if_id_instr_r;
    logic [31:0] if_id_pcplus4_r;
    logic        if_id_valid_r;
    logic        id_ex_mem_read_r;
    logic        id_ex_mem_write_r;
    logic        id_ex_reg_write_r;
    logic        id_ex_valid_r;
    logic [4:0]  id_ex_rs_r;
    logic [4:0]  id_ex_rt_r;
    logic [4:0]  id_ex_rd_r;
    logic [15:0] stall_count_r;
    logic [15:0] flush_count_r;

    // ------------------------------------------------------------------
    // Next-value signals
    // ------------------------------------------------------------------
    action_t     action_s;
    logic [31:0] pc_plus4_s;
    logic [31:0] nxt_pc_s;
    logic [31:0] nxt_if_id_instr_s;
    logic [31:0] nxt_if_id_pcplus4_s;
    logic        nxt_if_id_valid_s;
    logic        nxt_id_ex_mem_read_s;
    logic        nxt_id_ex_mem_write_s;
    logic        nxt_id_ex_reg_write_s;
    logic        nxt_id_ex_valid_s;
    logic [4:0]  nxt_id_ex_rs_s;
    logic [4:0]  nxt_id_ex_rt_s;
    logic [4:0]  nxt_id_ex_rd_s;
    logic [15:0] nxt_stall_count_s;
    logic [15:0] nxt_flush_count_s;

    // Sequential increment wraps naturally at 2^32.
    assign pc_plus4_s = pc_r + 32'd4;

    // Action select: a stall outranks a taken branch because the branch
    // operands are not yet valid; the branch is seen again next cycle.
    always_comb begin
        action_s = ACT_RUN;
        if (mem_wait) begin
            action_s = ACT_FREEZE;
        end else if (do_stall) begin
            action_s = ACT_STALL;
        end else if (branch_taken) begin
            action_s = ACT_FLUSH;
        end else begin
            action_s = ACT_RUN;
        end
    end

    // Next-value computation for the PC, pipeline registers and counters.
    always_comb begin
        // Default: hold everything (this is the whole FREEZE behaviour).
        nxt_pc_s              = pc_r;
        nxt_if_id_instr_s     = if_id_instr_r;
        nxt_if_id_pcplus4_s   = if_id_pcplus4_r;
        nxt_if_id_valid_s     = if_id_valid_r;
        nxt_id_ex_mem_read_s  = id_ex_mem_read_r;
        nxt_id_ex_mem_write_s = id_ex_mem_write_r;
        nxt_id_ex_reg_write_s = id_ex_reg_write_r;
        nxt_id_ex_valid_s     = id_ex_valid_r;
        nxt_id_ex_rs_s        = id_ex_rs_r;
        nxt_id_ex_rt_s        = id_ex_rt_r;
        nxt_id_ex_rd_s        = id_ex_rd_r;
        nxt_stall_count_s     = stall_count_r;
        nxt_flush_count_s     = flush_count_r;

        case (action_s)
            ACT_RUN: begin
                nxt_pc_s              = pc_plus4_s;
                nxt_if_id_instr_s     = if_instr;
                nxt_if_id_pcplus4_s   = pc_plus4_s;
                nxt_if_id_valid_s     = 1'b1;
                nxt_id_ex_mem_read_s  = id_memRead;
                nxt_id_ex_mem_write_s = id_memWrite;
                nxt_id_ex_reg_write_s = id_regWrite;
                nxt_id_ex_valid_s     = if_id_valid_r;
                nxt_id_ex_rs_s        = id_rs;
                nxt_id_ex_rt_s        = id_rt;
                nxt_id_ex_rd_s        = id_rd;
            end
            ACT_STALL: begin
                // PC and IF/ID hold; a fully zeroed bubble enters ID/EX.
                nxt_id_ex_mem_read_s  = 1'b0;
                nxt_id_ex_mem_write_s = 1'b0;
                nxt_id_ex_reg_write_s = 1'b0;
                nxt_id_ex_valid_s     = 1'b0;
                nxt_id_ex_rs_s        = 5'd0;
                nxt_id_ex_rt_s        = 5'd0;
                nxt_id_ex_rd_s        = 5'd0;
                nxt_stall_count_s     = sat_inc16(stall_count_r);
            end
            ACT_FLUSH: begin
                // The wrong-path fetch is squashed; the branch itself moves on.
                nxt_pc_s              = branch_target;
                nxt_if_id_instr_s     = 32'd0;
                nxt_if_id_pcplus4_s   = 32'd0;
                nxt_if_id_valid_s     = 1'b0;
                nxt_id_ex_mem_read_s  = id_memRead;
                nxt_id_ex_mem_write_s = id_memWrite;
                nxt_id_ex_reg_write_s = id_regWrite;
                nxt_id_ex_valid_s     = if_id_valid_r;
                nxt_id_ex_rs_s        = id_rs;
                nxt_id_ex_rt_s        = id_rt;
                nxt_id_ex_rd_s        = id_rd;
                nxt_flush_count_s     = sat_inc16(flush_count_r);
            end
            ACT_FREEZE: begin
                nxt_pc_s = pc_r;
            end
            default: begin
                nxt_pc_s = pc_r;
            end
        endcase
    end

    // State register: reset outranks every action, including a freeze.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r           <= ACT_RUN;
            pc_r              <= 32'd0;
            if_id_instr_r     <= 32'd0;
            if_id_pcplus4_r   <= 32'd0;
            if_id_valid_r     <= 1'b0;
            id_ex_mem_read_r  <= 1'b0;
            id_ex_mem_write_r <= 1'b0;
            id_ex_reg_write_r <= 1'b0;
            id_ex_valid_r     <= 1'b0;
            id_ex_rs_r        <= 5'd0;
            id_ex_rt_r        <= 5'd0;
            id_ex_rd_r        <= 5'd0;
            stall_count_r     <= 16'd0;
            flush_count_r     <= 16'd0;
        end else begin
            state_r           <= action_s;
            pc_r              <= nxt_pc_s;
            if_id_instr_r     <= nxt_if_id_instr_s;
            if_id_pcplus4_r   <= nxt_if_id_pcplus4_s;
            if_id_valid_r     <= nxt_if_id_valid_s;
            id_ex_mem_read_r  <= nxt_id_ex_mem_read_s;
            id_ex_mem_write_r <= nxt_id_ex_mem_write_s;
            id_ex_reg_write_r <= nxt_id_ex_reg_write_s;
            id_ex_valid_r     <= nxt_id_ex_valid_s;
            id_ex_rs_r        <= nxt_id_ex_rs_s;
            id_ex_rt_r        <= nxt_id_ex_rt_s;
            id_ex_rd_r        <= nxt_id_ex_rd_s;
            stall_count_r     <= nxt_stall_count_s;
            flush_count_r     <= nxt_flush_count_s;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all straight from registers; rs/rt are field slices of the
    // held instruction so the hazard detector sees them without delay.
    // ------------------------------------------------------------------
    assign pc             = pc_r;
    assign IF_ID_instr    = if_id_instr_r;
    assign IF_ID_pcplus4  = if_id_pcplus4_r;
    assign IF_ID_valid    = if_id_valid_r;
    assign IF_ID_rs       = if_id_instr_r[25:21];
    assign IF_ID_rt       = if_id_instr_r[20:16];
    assign ID_EX_memRead  = id_ex_mem_read_r;
    assign ID_EX_memWrite = id_ex_mem_write_r;
    assign ID_EX_regWrite = id_ex_reg_write_r;
    assign ID_EX_valid    = id_ex_valid_r;
    assign ID_EX_rs       = id_ex_rs_r;
    assign ID_EX_rt       = id_ex_rt_r;
    assign ID_EX_rd       = id_ex_rd_r;
    assign state          = state_r;
    assign stall_count    = stall_count_r;
    assign flush_count    = flush_count_r;

endmodule

// File: tb/tb_pipe_hold.sv
// -----------------------------------------------------------------------------
// tb_pipe_hold
// Self-checking bench for pipe_hold: directed scenarios followed by random
// traffic, every output compared after each edge against a reference model
// built from the action rules (reset > freeze > stall > flush > run).
// -----------------------------------------------------------------------------
module tb_pipe_hold;

    logic        clk;
    logic        reset;
    logic        do_stall;
    logic        mem_wait;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] if_instr;
    logic        id_memRead;
    logic        id_memWrite;
    logic        id_regWrite;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [31:0] pc;
    logic [31:0] IF_ID_instr;
    logic [31:0] IF_ID_pcplus4;
    logic        IF_ID_valid;
    logic [4:0]  IF_ID_rs;
    logic [4:0]  IF_ID_rt;
    logic        ID_EX_memRead;
    logic        ID_EX_memWrite;
    logic        ID_EX_regWrite;
    logic        ID_EX_valid;
    logic [4:0]  ID_EX_rs;
    logic [4:0]  ID_EX_rt;
    logic [4:0]  ID_EX_rd;
    logic [1:0]  state;
    logic [15:0] stall_count;
    logic [15:0] flush_count;

    int n_vec = 0;
    int n_err = 0;

    pipe_hold dut (
        .clk            (clk),
        .reset          (reset),
        .do_stall       (do_stall),
        .mem_wait       (mem_wait),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .if_instr       (if_instr),
        .id_memRead     (id_memRead),
        .id_memWrite    (id_memWrite),
        .id_regWrite    (id_regWrite),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_rd          (id_rd),
        .pc             (pc),
        .IF_ID_instr    (IF_ID_instr),
        .IF_ID_pcplus4  (IF_ID_pcplus4),
        .IF_ID_valid    (IF_ID_valid),
        .IF_ID_rs       (IF_ID_rs),
        .IF_ID_rt       (IF_ID_rt),
        .ID_EX_memRead  (ID_EX_memRead),
        .ID_EX_memWrite (ID_EX_memWrite),
        .ID_EX_regWrite (ID_EX_regWrite),
        .ID_EX_valid    (ID_EX_valid),
        .ID_EX_rs       (ID_EX_rs),
        .ID_EX_rt       (ID_EX_rt),
        .ID_EX_rd       (ID_EX_rd),
        .state          (state),
        .stall_count    (stall_count),
        .flush_count    (flush_count)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state (plain integers / words).
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_ifv;
    logic        m_mr, m_mw, m_rw, m_exv;
    logic [4:0]  m_rs, m_rt, m_rd;
    int          m_state, m_sc, m_fc;

    // Single checking point: counts the comparison and reports a miscompare.
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock edge of the reference model, taken from the action rules.
    task automatic model_edge();
        if (reset) begin
            m_pc = 32'd0; m_instr = 32'd0; m_pc4 = 32'd0; m_ifv = 1'b0;
            m_mr = 1'b0; m_mw = 1'b0; m_rw = 1'b0; m_exv = 1'b0;
            m_rs = 5'd0; m_rt = 5'd0; m_rd = 5'd0;
            m_state = 0; m_sc = 0; m_fc = 0;
        end else if (mem_wait) begin
            m_state = 3;
        end else if (do_stall) begin
            m_state = 3 - 2;
            m_mr = 1'b0; m_mw = 1'b0; m_rw = 1'b0; m_exv = 1'b0;
            m_rs = 5'd0; m_rt = 5'd0; m_rd = 5'd0;
            if (m_sc < 65535) m_sc = m_sc + 1;
        end else begin
            // RUN and FLUSH share the ID->EX advance.
            m_exv = m_ifv;
            m_mr = id_memRead; m_mw = id_memWrite; m_rw = id_regWrite;
            m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
            if (branch_taken) begin
                m_state = 2;
                m_pc = branch_target;
                m_instr = 32'd0; m_pc4 = 32'd0; m_ifv = 1'b0;
                if (m_fc < 65535) m_fc = m_fc + 1;
            end else begin
                m_state = 0;
                m_pc4 = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
                m_pc = m_pc4;
                m_instr = if_instr;
                m_ifv = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        check_val("pc",             pc,                    m_pc);
        check_val("IF_ID_instr",    IF_ID_instr,           m_instr);
        check_val("IF_ID_pcplus4",  IF_ID_pcplus4,         m_pc4);
        check_val("IF_ID_valid",    32'(IF_ID_valid),      32'(m_ifv));
        check_val("IF_ID_rs",       32'(IF_ID_rs),         32'(m_instr >> 21) & 32'h1F);
        check_val("IF_ID_rt",       32'(IF_ID_rt),         32'(m_instr >> 16) & 32'h1F);
        check_val("ID_EX_memRead",  32'(ID_EX_memRead),    32'(m_mr));
        check_val("ID_EX_memWrite", 32'(ID_EX_memWrite),   32'(m_mw));
        check_val("ID_EX_regWrite", 32'(ID_EX_regWrite),   32'(m_rw));
        check_val("ID_EX_valid",    32'(ID_EX_valid),      32'(m_exv));
        check_val("ID_EX_rs",       32'(ID_EX_rs),         32'(m_rs));
        check_val("ID_EX_rt",       32'(ID_EX_rt),         32'(m_rt));
        check_val("ID_EX_rd",       32'(ID_EX_rd),         32'(m_rd));
        check_val("state",          32'(state),            32'(m_state));
        check_val("stall_count",    32'(stall_count),      32'(m_sc));
        check_val("flush_count",    32'(flush_count),      32'(m_fc));
    endtask

    // Apply current inputs at the next rising edge, then compare #1 later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic drive(input logic r, input logic mw, input logic st, input logic bt,
                         input logic [31:0] tgt);
        reset = r; mem_wait = mw; do_stall = st; branch_taken = bt; branch_target = tgt;
        if_instr    = $urandom;
        id_memRead  = 1'($urandom);
        id_memWrite = 1'($urandom);
        id_regWrite = 1'($urandom);
        id_rs       = 5'($urandom);
        id_rt       = 5'($urandom);
        id_rd       = 5'($urandom);
    endtask

    logic [31:0] saved_pc;

    initial begin
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h1234_5678);
        m_pc = 32'd0; m_instr = 32'd0; m_pc4 = 32'd0; m_ifv = 1'b0;
        m_mr = 1'b0; m_mw = 1'b0; m_rw = 1'b0; m_exv = 1'b0;
        m_rs = 5'd0; m_rt = 5'd0; m_rd = 5'd0;
        m_state = 0; m_sc = 0; m_fc = 0;

        // Reset overrides freeze/stall/branch.
        step();
        step();
        check_val("rst_pc", pc, 32'h0);
        check_val("rst_state", 32'(state), 32'd0);

        // Three RUN cycles with a fixed lw instruction.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            if_instr = 32'h8C22_0004;
            step();
            if (i == 0) begin
                check_val("first_run_ifv", 32'(IF_ID_valid), 32'd1);
                check_val("first_run_exv", 32'(ID_EX_valid), 32'd0);
            end
        end
        check_val("run3_pc", pc, 32'h0000_000C);
        check_val("run3_pc4", IF_ID_pcplus4, 32'h0000_000C);
        check_val("run3_rt", 32'(IF_ID_rt), 32'd2);
        check_val("run3_state", 32'(state), 32'd0);

        // Reach pc 0x10, then two stall cycles.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        id_memRead = 1'b1;
        step();
        check_val("pc_10", pc, 32'h10);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
            id_memRead = 1'b1; id_rt = 5'd7;
            step();
            check_val("stall_pc", pc, 32'h10);
            check_val("stall_memRead", 32'(ID_EX_memRead), 32'd0);
            check_val("stall_rt", 32'(ID_EX_rt), 32'd0);
        end
        check_val("stall_cnt2", 32'(stall_count), 32'd2);
        check_val("stall_state", 32'(state), 32'd1);

        // Taken branch.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0400);
        step();
        check_val("flush_pc", pc, 32'h400);
        check_val("flush_ifv", 32'(IF_ID_valid), 32'd0);
        check_val("flush_instr", IF_ID_instr, 32'd0);
        check_val("flush_cnt", 32'(flush_count), 32'd1);
        check_val("flush_state", 32'(state), 32'd2);

        // Everything at once freezes; then the stall wins over the branch.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0800);
        step();
        check_val("freeze_pc", pc, 32'h400);
        check_val("freeze_state", 32'(state), 32'd3);
        check_val("freeze_sc", 32'(stall_count), 32'd2);
        mem_wait = 1'b0;
        step();
        check_val("unfreeze_pc", pc, 32'h400);
        check_val("unfreeze_sc", 32'(stall_count), 32'd3);
        check_val("unfreeze_state", 32'(state), 32'd1);

        // PC wrap.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        check_val("wrap_pc", pc, 32'h0000_0000);
        check_val("wrap_pc4", IF_ID_pcplus4, 32'h0000_0000);

        // Saturate the stall counter; pc must never move.
        saved_pc = pc;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 65536; i++) begin
            step();
        end
        check_val("sat_sc", 32'(stall_count), 32'h0000_FFFF);
        check_val("sat_pc", pc, saved_pc);
        step();
        check_val("sat_hold", 32'(stall_count), 32'h0000_FFFF);

        // Reset in the middle of the stall.
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
        step();
        check_val("rst_mid_pc", pc, 32'd0);
        check_val("rst_mid_sc", 32'(stall_count), 32'd0);
        check_val("rst_mid_fc", 32'(flush_count), 32'd0);
        check_val("rst_mid_state", 32'(state), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                  $urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
